// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache with configurable geometry.
// Combinational lookup, a two-state line-fill FSM driving a level-request /
// beat-valid memory port, whole-cache flush and saturating hit/miss counters.
module icache_dm_param #(
    parameter int ADDR_W      = 16,
    parameter int WORD_W      = 16,
    parameter int INDEX_BITS  = 7,
    parameter int OFFSET_BITS = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] address,
    input  logic              flush,
    output logic [WORD_W-1:0] instruction,
    output logic              hit,
    output logic              wait_for_memory,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W = ADDR_W - 1 - OFFSET_BITS - INDEX_BITS;
    localparam int LINES = 2 ** INDEX_BITS;
    localparam int WORDS = 2 ** OFFSET_BITS;
    localparam int LOW_W = OFFSET_BITS + 1;

    generate
        if (TAG_W < 1) begin : g_bad_geometry
            $error("icache_dm_param: ADDR_W too small for INDEX_BITS/OFFSET_BITS (TAG_W < 1)");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Arrays: valid bits are state, tag and data are plain storage.
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag_mem  [LINES];
    logic [WORD_W-1:0] r_data_mem [LINES*WORDS];

    logic [ADDR_W-1:0]      r_mem_addr;
    logic [OFFSET_BITS-1:0] r_beat;
    logic                   r_flush_pending;
    logic [CNT_W-1:0]       r_hit_count;
    logic [CNT_W-1:0]       r_miss_count;

    // Field extraction for the fetch address and the latched fill address.
    logic [OFFSET_BITS-1:0] w_word;
    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_W-1:0]       w_tag;
    logic [INDEX_BITS-1:0]  w_fill_index;
    logic [TAG_W-1:0]       w_fill_tag;
    logic                   w_unused_bit0;

    assign w_word        = address[OFFSET_BITS:1];
    assign w_index       = address[OFFSET_BITS+INDEX_BITS:OFFSET_BITS+1];
    assign w_tag         = address[ADDR_W-1 -: TAG_W];
    assign w_fill_index  = r_mem_addr[OFFSET_BITS+INDEX_BITS:OFFSET_BITS+1];
    assign w_fill_tag    = r_mem_addr[ADDR_W-1 -: TAG_W];
    assign w_unused_bit0 = address[0];

    logic w_line_hit;
    logic w_hit;
    logic w_start_fill;
    logic w_beat_wr;
    logic w_last_beat;
    logic w_drop_line;

    assign w_line_hit   = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    assign w_hit        = fetch_en && w_line_hit && (r_state == S_IDLE) && !flush;
    assign w_start_fill = (r_state == S_IDLE) && fetch_en && !w_line_hit && !flush;
    assign w_beat_wr    = (r_state == S_FILL) && mem_rvalid;
    assign w_last_beat  = w_beat_wr && (r_beat == '1);
    // A flush arriving on the final beat is treated like one seen earlier.
    assign w_drop_line  = r_flush_pending || flush;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values;
        // blocking = here would make results depend on statement order.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic: start a fill on a clean miss, finish on the last beat.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned,
        // which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_fill) w_next_state = S_FILL;
            S_FILL:  if (w_last_beat)  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: lookup result, stall and memory request.
    always_comb begin
        hit             = w_hit;
        instruction     = r_data_mem[{w_index, w_word}];
        mem_req         = (r_state == S_FILL);
        wait_for_memory = (r_state != S_IDLE) || (fetch_en && !w_hit);
    end

    // Fill bookkeeping: latched line address, beat counter, deferred flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr      <= '0;
            r_beat          <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            if (w_start_fill) begin
                r_mem_addr <= {address[ADDR_W-1:LOW_W], {LOW_W{1'b0}}};
                r_beat     <= '0;
            end else if (w_beat_wr) begin
                r_beat <= r_beat + OFFSET_BITS'(1);
            end
            if (w_last_beat)
                r_flush_pending <= 1'b0;
            else if ((r_state == S_FILL) && flush)
                r_flush_pending <= 1'b1;
        end
    end

    // Valid bits: cleared by flush (immediately in IDLE, at fill end otherwise).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if ((r_state == S_IDLE) && flush) begin
            r_valid <= '0;
        end else if (w_last_beat) begin
            if (w_drop_line) r_valid <= '0;
            else             r_valid[w_fill_index] <= 1'b1;
        end
    end

    // Tag and data storage writes.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays carry no reset; the valid bits alone make their
        // contents meaningful, so resetting them would only cost logic.
        if (w_beat_wr)
            r_data_mem[{w_fill_index, r_beat}] <= mem_rdata;
        if (w_last_beat && !w_drop_line)
            r_tag_mem[w_fill_index] <= w_fill_tag;
    end

    // Saturating counters: hit cycles and fills started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != '1))
                r_hit_count <= r_hit_count + CNT_W'(1);
            if (w_start_fill && (r_miss_count != '1))
                r_miss_count <= r_miss_count + CNT_W'(1);
        end
    end

    assign mem_addr   = r_mem_addr;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_dm_param.sv
// Bench for icache_dm_param: a directed vector table for the basic fill/hit
// sequence, hand-written flush/reset/saturation sequences, and random traffic
// checked every cycle against a line-level model of the cache.
module tb_icache_dm_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [15:0] address;
    logic        flush;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    logic [15:0] instruction, mem_addr, hit_count, miss_count;
    logic        hit, wait_for_memory, mem_req;

    logic [15:0] instruction4, mem_addr4;
    logic        hit4, wait4, mem_req4;
    logic [3:0]  hit_count4, miss_count4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_dm_param u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .address(address), .flush(flush),
        .instruction(instruction), .hit(hit), .wait_for_memory(wait_for_memory),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_dm_param #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .address(address), .flush(flush),
        .instruction(instruction4), .hit(hit4), .wait_for_memory(wait4),
        .mem_req(mem_req4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .hit_count(hit_count4), .miss_count(miss_count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (line granularity) ----------------
    bit          m_valid [128];
    logic [4:0]  m_tag   [128];
    logic [15:0] m_data  [128][8];
    bit          m_filling;
    bit          m_pend;
    logic [15:0] m_fill_addr;
    logic [15:0] m_beats [$];
    int          m_hits;
    int          m_misses;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit m_hit();
        int idx = int'(address[10:4]);
        return fetch_en && !flush && !m_filling && m_valid[idx] && (m_tag[idx] == address[15:11]);
    endfunction

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_filling = 1'b0;
        m_pend    = 1'b0;
        m_fill_addr = 16'h0;
        m_beats.delete();
        m_hits    = 0;
        m_misses  = 0;
    endtask

    task automatic model_check();
        bit eh = m_hit();
        bit ew = m_filling || (fetch_en && !eh);
        check("hit", hit, eh);
        check("wait_for_memory", wait_for_memory, ew);
        check("mem_req", mem_req, m_filling);
        if (m_filling) check("mem_addr", mem_addr, m_fill_addr);
        if (eh) check("instruction", instruction, m_data[int'(address[10:4])][int'(address[3:1])]);
        check("hit_count", hit_count, sat(m_hits, 65535));
        check("miss_count", miss_count, sat(m_misses, 65535));
        check("hit_count_w4", hit_count4, sat(m_hits, 15));
        check("miss_count_w4", miss_count4, sat(m_misses, 15));
    endtask

    task automatic model_update();
        if (!m_filling) begin
            if (m_hit()) m_hits++;
            if (flush) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
            end else if (fetch_en && !m_hit()) begin
                m_filling   = 1'b1;
                m_fill_addr = address & 16'hFFF0;
                m_beats.delete();
                m_misses++;
            end
        end else begin
            if (flush) m_pend = 1'b1;
            if (mem_rvalid) m_beats.push_back(mem_rdata);
            if (m_beats.size() == 8) begin
                int idx = int'(m_fill_addr[10:4]);
                if (!m_pend) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = m_fill_addr[15:11];
                    for (int w = 0; w < 8; w++) m_data[idx][w] = m_beats[w];
                end else begin
                    foreach (m_valid[i]) m_valid[i] = 1'b0;
                end
                m_filling = 1'b0;
                m_pend    = 1'b0;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc_begin(input logic fe, input logic [15:0] a, input logic fl,
                             input logic rv, input logic [15:0] rd);
        fetch_en = fe; address = a; flush = fl; mem_rvalid = rv; mem_rdata = rd;
        @(negedge clk);
        model_check();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input logic fe, input logic [15:0] a, input logic fl,
                        input logic rv, input logic [15:0] rd);
        cyc_begin(fe, a, fl, rv, rd);
        cyc_end();
    endtask

    // Miss cycle followed by 8 back-to-back beats; flush pulsed on beat flush_beat.
    task automatic fill_line(input logic [15:0] a, input logic [15:0] base, input int flush_beat);
        step(1'b1, a, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++)
            step(1'b1, a, (i == flush_beat), 1'b1, base + 16'(i));
    endtask

    task automatic do_reset();
        fetch_en = 1'b0; flush = 1'b0; mem_rvalid = 1'b0; address = 16'h0; mem_rdata = 16'h0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_hit", hit, 1'b0);
        check("rst_wait", wait_for_memory, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_hit_count", hit_count, 16'h0);
        check("rst_miss_count", miss_count, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        fe;
        logic [15:0] addr;
        logic        rv;
        logic [15:0] rd;
        logic        e_hit;
        logic        e_wait;
        logic        e_req;
        logic [15:0] e_maddr;
        logic [15:0] e_inst;
        logic [15:0] e_hitc;
        logic [15:0] e_missc;
    } vec_t;

    function automatic vec_t mk(input logic fe, input logic [15:0] a, input logic rv,
                                input logic [15:0] rd, input logic eh, input logic ew,
                                input logic er, input logic [15:0] ei,
                                input logic [15:0] ehc, input logic [15:0] emc);
        vec_t v;
        v.fe = fe; v.addr = a; v.rv = rv; v.rd = rd;
        v.e_hit = eh; v.e_wait = ew; v.e_req = er; v.e_maddr = 16'h0A40;
        v.e_inst = ei; v.e_hitc = ehc; v.e_missc = emc;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [$];
        logic [15:0] prev_miss;

        do_reset();

        // Miss, 8 beats with gaps after beats 2 and 5, then two hits and idle.
        tbl.push_back(mk(1, 16'h0A46, 0, 16'h0,    0, 1, 0, 16'h0,    0, 0));
        tbl.push_back(mk(1, 16'h0A46, 0, 16'h0,    0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 1, 16'h1000, 0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 1, 16'h1001, 0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 1, 16'h1002, 0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 0, 16'h0,    0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 1, 16'h1003, 0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 1, 16'h1004, 0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 1, 16'h1005, 0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 0, 16'h0,    0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 1, 16'h1006, 0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 1, 16'h1007, 0, 1, 1, 16'h0,    0, 1));
        tbl.push_back(mk(1, 16'h0A46, 0, 16'h0,    1, 0, 0, 16'h1003, 0, 1));
        tbl.push_back(mk(1, 16'h0A4E, 0, 16'h0,    1, 0, 0, 16'h1007, 1, 1));
        tbl.push_back(mk(0, 16'h0A4E, 0, 16'h0,    0, 0, 0, 16'h0,    2, 1));

        foreach (tbl[i]) begin
            cyc_begin(tbl[i].fe, tbl[i].addr, 1'b0, tbl[i].rv, tbl[i].rd);
            check($sformatf("vec%0d_hit", i), hit, tbl[i].e_hit);
            check($sformatf("vec%0d_wait", i), wait_for_memory, tbl[i].e_wait);
            check($sformatf("vec%0d_req", i), mem_req, tbl[i].e_req);
            if (tbl[i].e_req) check($sformatf("vec%0d_maddr", i), mem_addr, tbl[i].e_maddr);
            if (tbl[i].e_hit) check($sformatf("vec%0d_inst", i), instruction, tbl[i].e_inst);
            check($sformatf("vec%0d_hitc", i), hit_count, tbl[i].e_hitc);
            check($sformatf("vec%0d_missc", i), miss_count, tbl[i].e_missc);
            cyc_end();
        end

        // Eviction: same index, different tag, then the original line misses.
        fill_line(16'h1246, 16'h2000, -1);
        cyc_begin(1'b1, 16'h1246, 1'b0, 1'b0, 16'h0);
        check("evict_new_inst", instruction, 16'h2003);
        cyc_end();
        cyc_begin(1'b1, 16'h0A46, 1'b0, 1'b0, 16'h0);
        check("evict_old_miss", hit, 1'b0);
        cyc_end();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0A46, 1'b0, 1'b1, 16'h1000 + 16'(i));
        step(1'b1, 16'h0A46, 1'b0, 1'b0, 16'h0);

        // Flush in IDLE: hit suppressed that cycle, then the same address misses.
        cyc_begin(1'b1, 16'h0A46, 1'b1, 1'b0, 16'h0);
        check("flush_idle_hit_forced0", hit, 1'b0);
        prev_miss = miss_count;
        cyc_end();
        cyc_begin(1'b1, 16'h0A46, 1'b0, 1'b0, 16'h0);
        check("flush_idle_then_miss", hit, 1'b0);
        cyc_end();
        check("flush_idle_miss_count", miss_count, prev_miss + 16'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0A46, 1'b0, 1'b1, 16'h3000 + 16'(i));

        // Flush at beat 3 of a fill: fill completes but the line stays invalid.
        fill_line(16'h1A50, 16'h4000, 3);
        check("flush_fill_req_drop", mem_req, 1'b0);
        cyc_begin(1'b1, 16'h1A50, 1'b0, 1'b0, 16'h0);
        check("flush_fill_then_miss", hit, 1'b0);
        cyc_end();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h1A50, 1'b0, 1'b1, 16'h4100 + 16'(i));
        step(1'b1, 16'h1A50, 1'b0, 1'b0, 16'h0);

        // Reset at beat 4 of a fill; stray beats afterwards must not validate anything.
        step(1'b1, 16'h0A46, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0A46, 1'b0, 1'b1, 16'h5000 + 16'(i));
        mem_rvalid = 1'b1; mem_rdata = 16'h5004;
        #2;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0A46, 1'b0, 1'b1, 16'hDEA0 + 16'(i));
        cyc_begin(1'b1, 16'h0A46, 1'b0, 1'b0, 16'h0);
        check("stray_beats_no_hit", hit, 1'b0);
        cyc_end();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0A46, 1'b0, 1'b1, 16'h6000 + 16'(i));

        // Long hit run: the 4-bit counter saturates at 0xF.
        for (int i = 0; i < 20; i++) step(1'b1, 16'h0A40 | 16'(i % 16), 1'b0, 1'b0, 16'h0);
        check("sat_hit_count_w4", hit_count4, 4'hF);
        check("sat_hit_count_w16", hit_count, 16'd20);

        // Random traffic on two indices and three tags against the model.
        for (int n = 0; n < 600; n++) begin
            logic [4:0]  t;
            logic [6:0]  idx;
            logic [2:0]  w;
            logic [15:0] a;
            t   = 5'($urandom_range(1, 3));
            idx = 7'h24 + 7'($urandom_range(0, 1));
            w   = 3'($urandom_range(0, 7));
            a   = {t, idx, w, 1'($urandom_range(0, 1))};
            step(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_dm_param.md
Name: icache_dm_param

Overview:
- Parametrised direct-mapped instruction cache with an integrated line-fill FSM.
- Sits between the fetch stage and an external multi-beat instruction memory port.
- Generalises the fixed 16-bit / 128-line / 8-word cache to configurable geometry.
- Adds behaviour the fixed cache lacks: external req/valid memory handshake tolerating variable latency and beat gaps, whole-cache flush, and saturating hit/miss counters.

Parameters:
- ADDR_W, 16, byte-address width; bit 0 ignored (word-aligned fetch).
- WORD_W, 16, instruction/data word width.
- INDEX_BITS, 7, line index width; 2**INDEX_BITS lines.
- OFFSET_BITS, 3, word-offset width; 2**OFFSET_BITS words per line.
- CNT_W, 16, hit/miss counter width.
- Derived: TAG_W = ADDR_W-1-OFFSET_BITS-INDEX_BITS. Must be >= 1; elaboration error otherwise.

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- fetch_en, input, 1, fetch request valid this cycle.
- address, input, ADDR_W, fetch byte address. Fields: [OFFSET_BITS:1] = word, next INDEX_BITS = index, top TAG_W = tag.
- flush, input, 1, invalidate entire cache (1-cycle pulse).
- instruction, output, WORD_W, word at address; valid only when hit=1.
- hit, output, 1, fetch_en & line valid & tag match & state==IDLE.
- wait_for_memory, output, 1, high while state!=IDLE or (fetch_en & ~hit).
- mem_req, output, 1, level request; high for entire fill.
- mem_addr, output, ADDR_W, line-aligned byte address of fill (offset bits and bit 0 zero); stable while mem_req.
- mem_rdata, input, WORD_W, returned beat.
- mem_rvalid, input, 1, beat valid; beats return in ascending word order.
- hit_count, output, CNT_W, saturating count of hit cycles.
- miss_count, output, CNT_W, saturating count of fills started.

Behaviour:
- Reset (async assert): all valid bits 0, state IDLE, mem_req 0, mem_addr 0, beat counter 0, flush_pending 0, counters 0. instruction is don't-care, hit 0, wait_for_memory 0. Data array need not reset.
- Lookup is combinational, 0-cycle hit latency from address/fetch_en.
- IDLE:
  - On fetch_en & miss & ~flush: latch line address into mem_addr, assert mem_req next cycle, clear beat counter, miss_count+1, go FILL.
  - On flush (any fetch_en): clear all valid bits next edge; no fill starts that cycle; hit forced 0 that cycle.
- FILL:
  - Each mem_rvalid writes mem_rdata to data[latched index][beat], beat+1.
  - Cycles without rvalid hold state; no timeout.
  - On the last beat (beat==2**OFFSET_BITS-1 & rvalid):
    - write the tag and set valid, unless flush_pending;
    - drop mem_req next cycle; go IDLE.
- flush during FILL: set flush_pending. Fill runs to completion; the line is not validated; all valids cleared on the completion edge; flush_pending cleared.
- address/fetch_en may change during FILL. The fill uses the latched address. After return to IDLE, lookup uses the current address; a new miss starts a new fill immediately (back-to-back fills allowed, one IDLE cycle between).
- mem_rvalid in IDLE is ignored (no write, no state change).
- Counters: hit_count increments on each cycle hit=1. Both counters saturate at all-ones and do not wrap.
- Reset mid-fill: abort immediately, mem_req 0, valids cleared; beats arriving after reset deasserts are ignored.

Test Plan:
- Defaults. Reset, then fetch_en=1, address=0x0A46 → hit=0, wait=1. Next cycle mem_req=1, mem_addr=0x0A40, miss_count=1.
- Return 8 beats 0x1000..0x1007, with gaps after beats 2 and 5 → mem_req falls after beat 7. Next cycle address 0x0A46 gives hit=1, instruction=0x1003. Address 0x0A4E gives 0x1007. hit_count counts these cycles.
- Address 0x1246 (same index 0x24, different tag) → miss, refill with 0x2000..0x2007. Then 0x0A46 misses again (eviction confirmed).
- Pulse flush while in IDLE after a fill → next cycle the same address misses; miss_count increments.
- Pulse flush at beat 3 of a fill → fill completes, mem_req drops, same address then misses.
- Assert rst_n=0 at beat 4 of a fill → mem_req=0 immediately, counters 0. After release, stray rvalid beats cause no hit; preload hit_count to all-ones via long hit run (CNT_W=4 build) → stays 0xF.
